cia_bus_responder: RTL and testbench

Peripheral-side responder for the 6800-style synchronous CIA bus cycle. It sits behind the CIA bus synchronizer and takes already-synchronized E, chip select, R/_W, register select and data. It turns each E-qualified cycle into single-cycle register read/write strobes toward the controller's register file. On reads it drives the returned byte back onto the bus with a controlled output enable and hold time.

---
 rtl/cia_bus_pkg.sv | 27 ++
 rtl/edge_det.sv | 33 +++
 rtl/cia_bus_responder.sv | 204 ++++++++++++++++++++
 tb/tb_cia_bus_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cia_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cia_bus_pkg
//  Description : Shared types and constants for the CIA bus responder:
//                FSM state encoding, default read-data hold length and
//                register-select width.
//  Revision    : 1.0 - initial release
// ============================================================================
package cia_bus_pkg;

    // Responder bus-cycle states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_FETCH = 3'd1,
        ST_RD_DRIVE = 3'd2,
        ST_WR_WAIT  = 3'd3,
        ST_HOLD     = 3'd4
    } cia_state_t;

    // clk cycles the read data stays driven after synced E falls
    localparam int HOLD_CYCLES_DEFAULT = 2;

    // Width of the register select field
    localparam int CIA_ADDR_W = 4;

endpackage
`default_nettype wire

// File: rtl/edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : edge_det
//  Description : One-bit rise/fall pulse generator. Registers the input once
//                and produces single-cycle combinational rise/fall pulses
//                against the previous-cycle value.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_det (
    input  logic clk,
    input  logic _reset,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic r_sig_d;

    // Previous-cycle copy of the input; cleared so that a level already high
    // at reset release is reported as a rise on the first cycle.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= sig;
        end
    end

    assign rise = sig & ~r_sig_d;
    assign fall = ~sig & r_sig_d;

endmodule
`default_nettype wire

// File: rtl/cia_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cia_bus_responder
//  Description : Peripheral-side responder for the 6800-style synchronous
//                CIA bus cycle. Converts each E-qualified, chip-selected
//                cycle into a single-cycle register read or write strobe and
//                drives read data back onto the bus with an output enable
//                that is held for HOLD_CYCLES clocks after E falls.
//  Revision    : 1.0 - initial release
// ============================================================================
module cia_bus_responder
    import cia_bus_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
    parameter int ADDR_W      = CIA_ADDR_W
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              e_synced,
    input  logic              _cs_synced,
    input  logic              r_w_synced,
    input  logic [ADDR_W-1:0] rs_synced,
    input  logic [7:0]        data_synced,
    input  logic [7:0]        reg_rdata,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_rd,
    output logic              reg_wr,
    output logic [7:0]        reg_wdata,
    output logic [7:0]        data_out,
    output logic              data_oe
);

    // Hold counter must be able to represent HOLD_CYCLES itself
    localparam int CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

    // ------------------------------------------------------------------------
    // E edge detection
    // ------------------------------------------------------------------------
    logic w_e_rise;
    logic w_e_fall;

    edge_det u_e_edge (
        .clk    (clk),
        ._reset (_reset),
        .sig    (e_synced),
        .rise   (w_e_rise),
        .fall   (w_e_fall)
    );

    // ------------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------------
    cia_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [7:0]        r_reg_wdata;
    logic [7:0]        r_data_out;
    logic              r_data_oe;
    logic              r_reg_rd;
    logic              r_reg_wr;

    // Next-state values computed by the combinational process
    cia_state_t        w_state_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [ADDR_W-1:0] w_reg_addr_next;
    logic [7:0]        w_reg_wdata_next;
    logic [7:0]        w_data_out_next;
    logic              w_data_oe_next;
    logic              w_reg_rd_next;
    logic              w_reg_wr_next;

    // A new selected bus cycle begins on E rising with chip select active
    logic w_start;
    logic w_launch;

    assign w_start = w_e_rise & ~_cs_synced;

    // State, counter and output registers; everything clears on reset
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_data_out  <= '0;
            r_data_oe   <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_reg_wr    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_reg_addr  <= w_reg_addr_next;
            r_reg_wdata <= w_reg_wdata_next;
            r_data_out  <= w_data_out_next;
            r_data_oe   <= w_data_oe_next;
            r_reg_rd    <= w_reg_rd_next;
            r_reg_wr    <= w_reg_wr_next;
        end
    end

    // Bus-cycle FSM: next state, strobes, data capture and hold counting
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_reg_addr_next  = r_reg_addr;
        w_reg_wdata_next = r_reg_wdata;
        w_data_out_next  = r_data_out;
        w_data_oe_next   = r_data_oe;
        w_reg_rd_next    = 1'b0;
        w_reg_wr_next    = 1'b0;
        w_launch         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_launch = 1'b1;
                end
            end

            ST_RD_FETCH: begin
                if (_cs_synced) begin
                    // Deselected before data was driven; the read strobe
                    // already went out and is simply left as issued.
                    w_data_oe_next = 1'b0;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_data_out_next = reg_rdata;
                    w_data_oe_next  = 1'b1;
                    w_state_next    = ST_RD_DRIVE;
                end
            end

            ST_RD_DRIVE: begin
                if (_cs_synced) begin
                    w_data_oe_next = 1'b0;
                    w_state_next   = ST_IDLE;
                end else if (w_e_fall) begin
                    if (HOLD_CYCLES == 0) begin
                        w_data_oe_next = 1'b0;
                        w_state_next   = ST_IDLE;
                    end else begin
                        w_cnt_next   = CNT_W'(HOLD_CYCLES);
                        w_state_next = ST_HOLD;
                    end
                end
            end

            ST_WR_WAIT: begin
                if (_cs_synced) begin
                    // Abort wins over a coincident E fall: no write strobe
                    w_data_oe_next = 1'b0;
                    w_state_next   = ST_IDLE;
                end else if (w_e_fall) begin
                    w_reg_wdata_next = data_synced;
                    w_reg_wr_next    = 1'b1;
                    w_state_next     = ST_IDLE;
                end
            end

            ST_HOLD: begin
                if (w_start) begin
                    // E low was shorter than the hold: cut the hold short
                    // and service the new cycle straight away.
                    w_data_oe_next = 1'b0;
                    w_cnt_next     = '0;
                    w_launch       = 1'b1;
                end else if (r_cnt <= CNT_W'(1)) begin
                    // Last hold cycle: the enable drops on the next clock
                    w_data_oe_next = 1'b0;
                    w_cnt_next     = '0;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end

            default: begin
                w_data_oe_next = 1'b0;
                w_cnt_next     = '0;
                w_state_next   = ST_IDLE;
            end
        endcase

        // Start of a selected cycle, shared by IDLE and the HOLD preempt
        if (w_launch) begin
            w_reg_addr_next = rs_synced;
            if (r_w_synced) begin
                w_reg_rd_next = 1'b1;
                w_state_next  = ST_RD_FETCH;
            end else begin
                w_state_next  = ST_WR_WAIT;
            end
        end
    end

    assign reg_addr  = r_reg_addr;
    assign reg_rd    = r_reg_rd;
    assign reg_wr    = r_reg_wr;
    assign reg_wdata = r_reg_wdata;
    assign data_out  = r_data_out;
    assign data_oe   = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_cia_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cia_bus_responder
//  Description : Self-checking bench for cia_bus_responder. Register strobes
//                are matched against a queue of expected transactions; bus
//                enable/data timing is checked at fixed cycle offsets. A
//                second instance with HOLD_CYCLES=8 covers the hold preempt.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cia_bus_responder;

    logic       clk;
    logic       rst_n;
    logic       e;
    logic       cs_n;
    logic       rw;
    logic [3:0] rs;
    logic [7:0] din;
    logic [7:0] rdata;

    logic [3:0] reg_addr;
    logic       reg_rd;
    logic       reg_wr;
    logic [7:0] reg_wdata;
    logic [7:0] data_out;
    logic       data_oe;

    logic [3:0] reg_addr8;
    logic       reg_rd8;
    logic       reg_wr8;
    logic [7:0] reg_wdata8;
    logic [7:0] data_out8;
    logic       data_oe8;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       is_wr;
        logic [3:0] addr;
        logic [7:0] data;
    } sb_item_t;

    sb_item_t sb_q[$];

    cia_bus_responder #(.HOLD_CYCLES(2), .ADDR_W(4)) dut (
        .clk         (clk),
        ._reset      (rst_n),
        .e_synced    (e),
        ._cs_synced  (cs_n),
        .r_w_synced  (rw),
        .rs_synced   (rs),
        .data_synced (din),
        .reg_rdata   (rdata),
        .reg_addr    (reg_addr),
        .reg_rd      (reg_rd),
        .reg_wr      (reg_wr),
        .reg_wdata   (reg_wdata),
        .data_out    (data_out),
        .data_oe     (data_oe)
    );

    cia_bus_responder #(.HOLD_CYCLES(8), .ADDR_W(4)) dut8 (
        .clk         (clk),
        ._reset      (rst_n),
        .e_synced    (e),
        ._cs_synced  (cs_n),
        .r_w_synced  (rw),
        .rs_synced   (rs),
        .data_synced (din),
        .reg_rdata   (rdata),
        .reg_addr    (reg_addr8),
        .reg_rd      (reg_rd8),
        .reg_wr      (reg_wr8),
        .reg_wdata   (reg_wdata8),
        .data_out    (data_out8),
        .data_oe     (data_oe8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_push(input logic is_wr, input logic [3:0] addr, input logic [7:0] data);
        sb_item_t it;
        it.is_wr = is_wr;
        it.addr  = addr;
        it.data  = data;
        sb_q.push_back(it);
    endtask

    task automatic gap(input int n);
        e    = 1'b0;
        cs_n = 1'b1;
        cycles(n);
    endtask

    // Strobe scoreboard for the HOLD_CYCLES=2 instance
    always @(negedge clk) begin
        if (rst_n && (reg_rd || reg_wr)) begin
            sb_item_t it;
            check_eq("strobe_excl", {31'd0, reg_rd & reg_wr}, 32'd0);
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected", {30'd0, reg_rd, reg_wr}, 32'd0);
            end else begin
                it = sb_q.pop_front();
                check_eq("sb_kind", {31'd0, reg_wr}, {31'd0, it.is_wr});
                check_eq("sb_addr", {28'd0, reg_addr}, {28'd0, it.addr});
                if (it.is_wr) begin
                    check_eq("sb_wdata", {24'd0, reg_wdata}, {24'd0, it.data});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        e     = 1'b0;
        cs_n  = 1'b1;
        rw    = 1'b0;
        rs    = 4'h0;
        din   = 8'h00;
        rdata = 8'h00;

        // Reset state
        cycles(2);
        check_eq("rst_rd",    {31'd0, reg_rd}, 32'd0);
        check_eq("rst_wr",    {31'd0, reg_wr}, 32'd0);
        check_eq("rst_oe",    {31'd0, data_oe}, 32'd0);
        check_eq("rst_dout",  {24'd0, data_out}, 32'd0);
        check_eq("rst_addr",  {28'd0, reg_addr}, 32'd0);
        check_eq("rst_wdata", {24'd0, reg_wdata}, 32'd0);
        rst_n = 1'b1;
        cycles(2);

        // Read rs=3, data A5
        rdata = 8'hA5; rs = 4'h3; rw = 1'b1; cs_n = 1'b0;
        sb_push(1'b0, 4'h3, 8'h00);
        e = 1'b1;
        cycles(1);
        check_eq("rd_strobe", {31'd0, reg_rd}, 32'd1);
        check_eq("rd_addr",   {28'd0, reg_addr}, 32'd3);
        check_eq("rd_oe_t1",  {31'd0, data_oe}, 32'd0);
        cycles(1);
        check_eq("rd_oe_t2",  {31'd0, data_oe}, 32'd1);
        check_eq("rd_dout",   {24'd0, data_out}, 32'hA5);
        check_eq("rd_single", {31'd0, reg_rd}, 32'd0);
        cycles(4);
        e = 1'b0;
        cycles(1);
        check_eq("rd_hold_f1", {31'd0, data_oe}, 32'd1);
        cycles(1);
        check_eq("rd_hold_f2", {31'd0, data_oe}, 32'd1);
        cycles(1);
        check_eq("rd_hold_f3", {31'd0, data_oe}, 32'd0);
        gap(12);
        check_eq("dout_keep", {24'd0, data_out}, 32'hA5);

        // Write rs=D, data 5C
        rs = 4'hD; rw = 1'b0; din = 8'h5C; cs_n = 1'b0;
        sb_push(1'b1, 4'hD, 8'h5C);
        e = 1'b1;
        cycles(4);
        check_eq("wr_early", {31'd0, reg_wr}, 32'd0);
        check_eq("wr_oe",    {31'd0, data_oe}, 32'd0);
        e = 1'b0;
        cycles(1);
        check_eq("wr_strobe", {31'd0, reg_wr}, 32'd1);
        check_eq("wr_wdata",  {24'd0, reg_wdata}, 32'h5C);
        check_eq("wr_addr",   {28'd0, reg_addr}, 32'hD);
        cycles(1);
        check_eq("wr_single", {31'd0, reg_wr}, 32'd0);
        check_eq("wr_oe2",    {31'd0, data_oe}, 32'd0);
        gap(12);

        // Deselected for five E periods
        cs_n = 1'b1; rw = 1'b1; rs = 4'h6;
        for (int p = 0; p < 5; p++) begin
            e = 1'b1;
            cycles(3);
            check_eq("nocs_oe_hi", {31'd0, data_oe}, 32'd0);
            check_eq("nocs_strb",  {30'd0, reg_rd, reg_wr}, 32'd0);
            e = 1'b0;
            cycles(3);
            check_eq("nocs_oe_lo", {31'd0, data_oe}, 32'd0);
        end
        gap(12);

        // Write aborted mid E-high, then a normal read of rs=1
        rs = 4'h7; rw = 1'b0; din = 8'h11; cs_n = 1'b0;
        e = 1'b1;
        cycles(2);
        cs_n = 1'b1;
        cycles(2);
        e = 1'b0;
        cycles(3);
        check_eq("abort_nowr", {31'd0, reg_wr}, 32'd0);
        gap(4);
        rdata = 8'h3C; rs = 4'h1; rw = 1'b1; cs_n = 1'b0;
        sb_push(1'b0, 4'h1, 8'h00);
        e = 1'b1;
        cycles(2);
        check_eq("post_abort_oe",   {31'd0, data_oe}, 32'd1);
        check_eq("post_abort_dout", {24'd0, data_out}, 32'h3C);
        cycles(2);
        e = 1'b0;
        cycles(3);
        check_eq("post_abort_rel", {31'd0, data_oe}, 32'd0);
        gap(12);

        // Reset asserted during RD_DRIVE, then write FF to rs=0
        rdata = 8'h77; rs = 4'h2; rw = 1'b1; cs_n = 1'b0;
        sb_push(1'b0, 4'h2, 8'h00);
        e = 1'b1;
        cycles(4);
        check_eq("rst_rd_oe", {31'd0, data_oe}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_oe",   {31'd0, data_oe}, 32'd0);
        check_eq("arst_dout", {24'd0, data_out}, 32'd0);
        check_eq("arst_addr", {28'd0, reg_addr}, 32'd0);
        e = 1'b0; cs_n = 1'b1;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        rs = 4'h0; rw = 1'b0; din = 8'hFF; cs_n = 1'b0;
        sb_push(1'b1, 4'h0, 8'hFF);
        e = 1'b1;
        cycles(3);
        e = 1'b0;
        cycles(1);
        check_eq("post_rst_wr",    {31'd0, reg_wr}, 32'd1);
        check_eq("post_rst_wdata", {24'd0, reg_wdata}, 32'hFF);
        gap(15);

        // HOLD_CYCLES=8 instance: short E-low lands the next E rise in HOLD
        rdata = 8'h5A; rs = 4'h4; rw = 1'b1; cs_n = 1'b0;
        sb_push(1'b0, 4'h4, 8'h00);
        e = 1'b1;
        cycles(3);
        check_eq("h8_oe_on", {31'd0, data_oe8}, 32'd1);
        e = 1'b0;
        cycles(3);
        check_eq("h8_in_hold", {31'd0, data_oe8}, 32'd1);
        rs = 4'h9;
        sb_push(1'b0, 4'h9, 8'h00);
        e = 1'b1;
        cycles(1);
        check_eq("h8_preempt_oe", {31'd0, data_oe8}, 32'd0);
        check_eq("h8_new_rd",     {31'd0, reg_rd8}, 32'd1);
        check_eq("h8_new_addr",   {28'd0, reg_addr8}, 32'd9);
        cycles(1);
        check_eq("h8_new_oe",   {31'd0, data_oe8}, 32'd1);
        check_eq("h8_new_dout", {24'd0, data_out8}, 32'h5A);
        cycles(1);
        e = 1'b0;
        gap(14);
        check_eq("h8_final_oe", {31'd0, data_oe8}, 32'd0);

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
